// File: rtl/processador_multiciclo.sv
// Multi-cycle 16-bit processor: eight registers, shared bus, 2-bit step counter.
// Optional macro PROC_LOGIC_OPS_EN turns opcodes 100/101 into and/xor.

module proc_reg (
  input  logic        clk,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] Q
);
  // General registers are deliberately left without a reset.
  always_ff @(posedge clk) begin
    if (en) Q <= d;
  end
endmodule

module processador_multiciclo (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] DIN,
  input  logic        Run,
  output logic        Done,
  output logic [15:0] BusWires
);
  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

  step_t       Tstep, next_step;
  logic [8:0]  IR;
  logic [15:0] A, G, alu_result;
  logic [2:0]  opcode, rx, ry;
  logic [7:0]  rx_oh, ry_oh, r_in, r_out;
  logic        g_out, din_out, a_in, g_in, ir_in, three_step;
  logic [15:0] r_q [8];

  assign opcode = IR[8:6];
  assign rx     = IR[5:3];
  assign ry     = IR[2:0];
  assign rx_oh  = 8'b1 << rx;
  assign ry_oh  = 8'b1 << ry;

`ifdef PROC_LOGIC_OPS_EN
  assign three_step = (opcode == 3'b010) || (opcode == 3'b011) ||
                      (opcode == 3'b100) || (opcode == 3'b101);
`else
  assign three_step = (opcode == 3'b010) || (opcode == 3'b011);
`endif

  proc_reg R0 (.clk(Clock), .en(r_in[0]), .d(BusWires), .Q(r_q[0]));
  proc_reg R1 (.clk(Clock), .en(r_in[1]), .d(BusWires), .Q(r_q[1]));
  proc_reg R2 (.clk(Clock), .en(r_in[2]), .d(BusWires), .Q(r_q[2]));
  proc_reg R3 (.clk(Clock), .en(r_in[3]), .d(BusWires), .Q(r_q[3]));
  proc_reg R4 (.clk(Clock), .en(r_in[4]), .d(BusWires), .Q(r_q[4]));
  proc_reg R5 (.clk(Clock), .en(r_in[5]), .d(BusWires), .Q(r_q[5]));
  proc_reg R6 (.clk(Clock), .en(r_in[6]), .d(BusWires), .Q(r_q[6]));
  proc_reg R7 (.clk(Clock), .en(r_in[7]), .d(BusWires), .Q(r_q[7]));

  always_comb begin
    Done      = 1'b0;
    r_in      = '0;
    r_out     = '0;
    g_out     = 1'b0;
    din_out   = 1'b0;
    a_in      = 1'b0;
    g_in      = 1'b0;
    ir_in     = 1'b0;
    next_step = Tstep;
    unique case (Tstep)
      T0: begin
        ir_in     = Run;
        next_step = Run ? T1 : T0;
      end
      T1: begin
        if (opcode == 3'b000) begin
          r_out = ry_oh;
          r_in  = rx_oh;
          Done  = 1'b1;
        end else if (opcode == 3'b001) begin
          din_out = 1'b1;
          r_in    = rx_oh;
          Done    = 1'b1;
        end else if (three_step) begin
          r_out = rx_oh;
          a_in  = 1'b1;
        end else begin
          Done = 1'b1;
        end
        next_step = Done ? T0 : T2;
      end
      T2: begin
        r_out     = ry_oh;
        g_in      = 1'b1;
        next_step = T3;
      end
      T3: begin
        g_out     = 1'b1;
        r_in      = rx_oh;
        Done      = 1'b1;
        next_step = T0;
      end
    endcase
  end

  // Selects are one-hot, so OR-ing the gated sources forms the mux; idle bus reads zero.
  always_comb begin
    BusWires = '0;
    for (int i = 0; i < 8; i++) begin
      if (r_out[i]) BusWires = BusWires | r_q[i];
    end
    if (g_out)   BusWires = BusWires | G;
    if (din_out) BusWires = BusWires | DIN;
  end

  always_comb begin
    case (opcode)
      3'b011:  alu_result = A - BusWires;
`ifdef PROC_LOGIC_OPS_EN
      3'b100:  alu_result = A & BusWires;
      3'b101:  alu_result = A ^ BusWires;
`endif
      default: alu_result = A + BusWires;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Tstep <= T0;
      IR    <= '0;
      A     <= '0;
      G     <= '0;
    end else begin
      Tstep <= next_step;
      if (ir_in) IR <= DIN[8:0];
      if (a_in)  A  <= BusWires;
      if (g_in)  G  <= alu_result;
    end
  end
endmodule

// File: tb/tb_processador_multiciclo.sv
// Randomized self-checking bench: per-instruction bus/Done sequences from an ISA-level model.
module tb_processador_multiciclo;
  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Run;
  logic [15:0] DIN;
  logic        Done;
  logic [15:0] BusWires;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] model [8];
  logic [7:0]  known = '0;
  bit          chk_valid = 1'b0;
  logic        exp_done = 1'b0;
  logic [15:0] exp_bus = '0;

  processador_multiciclo dut (
    .Clock(Clock), .Resetn(Resetn), .DIN(DIN), .Run(Run),
    .Done(Done), .BusWires(BusWires)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_reg(input int i);
    case (i)
      0: return dut.R0.Q;
      1: return dut.R1.Q;
      2: return dut.R2.Q;
      3: return dut.R3.Q;
      4: return dut.R4.Q;
      5: return dut.R5.Q;
      6: return dut.R6.Q;
      default: return dut.R7.Q;
    endcase
  endfunction

  function automatic bit is_alu(input logic [2:0] op);
`ifdef PROC_LOGIC_OPS_EN
    return op inside {3'd2, 3'd3, 3'd4, 3'd5};
`else
    return op inside {3'd2, 3'd3};
`endif
  endfunction

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Compare process: checks bus and Done every cycle an expectation is armed.
  always @(negedge Clock) begin
    #2;
    if (chk_valid) begin
      check("done", {15'b0, Done}, {15'b0, exp_done});
      check("bus", BusWires, exp_bus);
    end
  end

  task automatic check_regs();
    for (int i = 0; i < 8; i++)
      if (known[i]) check($sformatf("R%0d", i), dut_reg(i), model[i]);
  endtask

  task automatic run_instr(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                           input logic [15:0] imm);
    logic [15:0] bus_q[$];
    logic        done_q[$];
    logic [15:0] res;
    bit          wr;
    wr  = 1'b1;
    res = '0;
    if (op == 3'd0) begin
      res = model[y]; bus_q.push_back(model[y]); done_q.push_back(1'b1);
    end else if (op == 3'd1) begin
      res = imm; bus_q.push_back(imm); done_q.push_back(1'b1);
    end else if (is_alu(op)) begin
      res = alu(op, model[x], model[y]);
      bus_q.push_back(model[x]); done_q.push_back(1'b0);
      bus_q.push_back(model[y]); done_q.push_back(1'b0);
      bus_q.push_back(res);      done_q.push_back(1'b1);
    end else begin
      wr = 1'b0; bus_q.push_back(16'h0000); done_q.push_back(1'b1);
    end
    @(negedge Clock);
    DIN = {7'b0, op, x, y}; Run = 1'b1;
    exp_bus = '0; exp_done = 1'b0; chk_valid = 1'b1;
    for (int i = 0; i < bus_q.size(); i++) begin
      @(negedge Clock);
      Run = 1'($urandom_range(0, 1));
      DIN = (op == 3'd1) ? imm : 16'($urandom);
      exp_bus = bus_q[i]; exp_done = done_q[i];
    end
    if (wr) begin
      model[x] = res;
      known[x] = 1'b1;
    end
    @(negedge Clock);
    Run = 1'b0; DIN = 16'($urandom); exp_bus = '0; exp_done = 1'b0;
    #3;
    check("tstep_idle", {14'b0, dut.Tstep}, 16'd0);
    check_regs();
  endtask

  initial begin
    Resetn = 1'b0; Run = 1'b0; DIN = '0;
    #1;
    check("rst_tstep", {14'b0, dut.Tstep}, 16'd0);
    check("rst_done", {15'b0, Done}, 16'd0);
    check("rst_bus", BusWires, 16'h0000);
    @(negedge Clock);
    Resetn = 1'b1;
    chk_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      #3;
      check("idle_tstep", {14'b0, dut.Tstep}, 16'd0);
    end

    // Hand-computed anchors for the model.
    run_instr(3'd1, 3'd0, 3'd0, 16'd11);
    run_instr(3'd1, 3'd1, 3'd0, 16'd10);
    run_instr(3'd0, 3'd0, 3'd1, 16'd0);
    check("lit_mv", dut_reg(0), 16'd10);
    run_instr(3'd1, 3'd2, 3'd0, 16'd5);
    check("lit_mvi", dut_reg(2), 16'd5);
    run_instr(3'd1, 3'd0, 3'd0, 16'd11);
    run_instr(3'd2, 3'd0, 3'd1, 16'd0);
    check("lit_add", dut_reg(0), 16'd21);
    check("lit_add_src", dut_reg(1), 16'd10);
    run_instr(3'd1, 3'd3, 3'd0, 16'd3);
    run_instr(3'd1, 3'd4, 3'd0, 16'd5);
    run_instr(3'd3, 3'd3, 3'd4, 16'd0);
    check("lit_sub_wrap", dut_reg(3), 16'hFFFE);
`ifdef PROC_LOGIC_OPS_EN
    run_instr(3'd1, 3'd0, 3'd0, 16'h00FF);
    run_instr(3'd1, 3'd1, 3'd0, 16'h0F0F);
    run_instr(3'd4, 3'd0, 3'd1, 16'd0);
    check("lit_and", dut_reg(0), 16'h000F);
`endif

    // Reset in the middle of an add must leave the destination untouched.
    run_instr(3'd1, 3'd5, 3'd0, 16'd7);
    run_instr(3'd1, 3'd6, 3'd0, 16'd9);
    @(negedge Clock);
    chk_valid = 1'b0;
    DIN = {7'b0, 3'd2, 3'd5, 3'd6}; Run = 1'b1;
    @(negedge Clock);
    Run = 1'b0;
    @(negedge Clock);
    #1 Resetn = 1'b0;
    #1;
    check("midrst_tstep", {14'b0, dut.Tstep}, 16'd0);
    check("midrst_done", {15'b0, Done}, 16'd0);
    check("midrst_bus", BusWires, 16'h0000);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    #3;
    check("midrst_dest", dut_reg(5), 16'd7);
    check_regs();

    for (int i = 0; i < 8; i++) run_instr(3'd1, 3'(i), 3'd0, 16'($urandom));
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge Clock);
        chk_valid = 1'b1; Run = 1'b0; DIN = 16'($urandom);
        exp_bus = '0; exp_done = 1'b0;
      end
      run_instr(3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
    end
    chk_valid = 1'b0;
    check_regs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
